// File: rtl/fetch_pkg.sv
// Shared fetch-path types: the stored PC/instruction pair and the canonical NOP
// (addi x0,x0,0) that is presented toward decode whenever no entry is valid.
package fetch_pkg;

    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_INST_W = 32;

    localparam logic [FETCH_INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// IF->ID decoupling FIFO with flush-on-redirect. Define FETCH_BUFFER_BYPASS_EN to let
// an empty buffer forward the offered entry to decode in the same cycle without storing it.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [ADDR_W-1:0]        push_pc,
    input  logic [INST_W-1:0]        push_inst,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [ADDR_W-1:0]        pop_pc,
    output logic [INST_W-1:0]        pop_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    fetch_entry_t       mem [DEPTH];
    fetch_entry_t       head;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               empty;
    logic               full;
    logic               bypass;
    logic               push_fire;
    logic               pop_fire;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_ONE;
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);

    // Ready depends only on occupancy, so a full buffer refuses pushes even when popping.
    assign push_ready = rst && !full;

`ifdef FETCH_BUFFER_BYPASS_EN
    assign bypass = rst && empty && push_valid && pop_ready && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign push_fire = push_valid && push_ready && !flush && !bypass;
    assign pop_fire  = rst && pop_ready && !empty && !flush;
    assign head      = mem[rd_ptr];

    always_comb begin
        pop_valid = 1'b0;
        pop_pc    = '0;
        pop_inst  = INST_W'(NOP_INST);
        if (bypass) begin
            pop_valid = 1'b1;
            pop_pc    = push_pc;
            pop_inst  = push_inst;
        end else if (rst && !flush && !empty) begin
            pop_valid = 1'b1;
            pop_pc    = ADDR_W'(head.pc);
            pop_inst  = INST_W'(head.inst);
        end
    end

    // Control state: flush wins over any handshake in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) wr_ptr <= next_ptr(wr_ptr);
            if (pop_fire)  rd_ptr <= next_ptr(rd_ptr);
            case ({push_fire, pop_fire})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; stale slots are never visible because count gates the head.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= '{pc: FETCH_ADDR_W'(push_pc), inst: FETCH_INST_W'(push_inst)};
        end
    end

endmodule
